// File: rtl/time_unit_counter.sv
// Modulo-N time-unit counter (seconds/minutes/hours) with carry chaining and per-digit edit.
// Define AUTOREPEAT_EN to enable press-and-hold auto-repeat on the inc/dec buttons.
module time_unit_counter #(
  parameter int MODULO       = 60,
  parameter int WIDTH        = 7,
  parameter int CHAINED      = 0,
  parameter int TICK_DIV     = 50000000,
  parameter int FAST_DIV     = 13888,
  parameter int CUR_UNITS    = 5,
  parameter int CUR_TENS     = 4,
  parameter int DIS_MODE     = 0,
  parameter int REPEAT_START = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             Clk,
  input  logic             KEY0,
  input  logic             cin,
  input  logic             fast,
  input  logic             editMode,
  input  logic [2:0]       editCur,
  input  logic [1:0]       disMode,
  input  logic             inc_n,
  input  logic             dec_n,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             at_max
);

  if (MODULO < 2 || MODULO > 100 || (MODULO - 1) >= (1 << WIDTH) ||
      REPEAT_START < 1 || REPEAT_RATE < 1) begin : g_param_err
    $error("time_unit_counter: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAXT10 = WIDTH'((MODULO - 1) / 10 * 10);
  localparam logic [WIDTH-1:0] TEN    = WIDTH'(10);
  localparam logic [WIDTH-1:0] NINE   = WIDTH'(9);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  // bit 0 = inc, bit 1 = dec
  logic [1:0] pin, s1_q, s2_q, s3_q, evt_q, evt_d, fall;
  assign pin  = {dec_n, inc_n};
  assign fall = s3_q & ~s2_q;

  always_ff @(posedge Clk or negedge KEY0) begin
    if (!KEY0) begin
      s1_q  <= '1;
      s2_q  <= '1;
      s3_q  <= '1;
      evt_q <= '0;
    end else begin
      s1_q  <= pin;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      evt_q <= evt_d;
    end
  end

`ifdef AUTOREPEAT_EN
  logic [1:0][31:0] rpt_cnt_q, rpt_cnt_d;
  logic [1:0]       rpt_arm_q, rpt_arm_d, rpt;
  logic             both_held;

  // First repeat after REPEAT_START held cycles, then every REPEAT_RATE.
  always_comb begin
    both_held = ~s2_q[0] & ~s2_q[1];
    for (int b = 0; b < 2; b++) begin
      rpt_cnt_d[b] = '0;
      rpt_arm_d[b] = 1'b0;
      rpt[b]       = 1'b0;
      if (!s2_q[b] && !both_held) begin
        rpt[b]       = rpt_cnt_q[b] == (rpt_arm_q[b] ? 32'(REPEAT_RATE) : 32'(REPEAT_START));
        rpt_arm_d[b] = rpt_arm_q[b] | rpt[b];
        rpt_cnt_d[b] = rpt[b] ? 32'd1 : rpt_cnt_q[b] + 32'd1;
      end
    end
    evt_d = (fall | rpt) & ~{2{both_held}};
  end

  always_ff @(posedge Clk or negedge KEY0) begin
    if (!KEY0) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end
`else
  always_comb evt_d = fall;
`endif

  logic [31:0]      presc_q, presc_d, div_m1;
  logic             fast_q, em_q, carry_q, carry_d, tick;
  logic [WIDTH-1:0] value_q, value_d, u, t10, room, nv;
  logic             edit_ok, on_units, inc_e, dec_e;

  always_comb begin
    div_m1  = fast ? 32'(FAST_DIV - 1) : 32'(TICK_DIV - 1);
    presc_d = presc_q + 32'd1;
    tick    = 1'b0;
    if (CHAINED != 0 || editMode || fast != fast_q) begin
      presc_d = '0;
    end else if (presc_q == div_m1) begin
      presc_d = '0;
      tick    = 1'b1;
    end
    if (CHAINED != 0) tick = cin;
  end

  // Edit window stays open one extra cycle so a press coinciding with editMode falling still lands.
  always_comb begin
    u        = value_q % TEN;
    t10      = value_q - u;
    room     = MAXV - t10;
    on_units = editCur == 3'(CUR_UNITS);
    edit_ok  = (editMode || em_q) && disMode == 2'(DIS_MODE) &&
               (on_units || editCur == 3'(CUR_TENS));
    inc_e    = evt_q[0] & ~evt_q[1];
    dec_e    = evt_q[1] & ~evt_q[0];
    nv       = value_q;
    value_d  = value_q;
    carry_d  = 1'b0;
    if (edit_ok && (inc_e || dec_e)) begin
      if (on_units) begin
        if (inc_e) nv = (u == NINE || value_q == MAXV) ? t10 : value_q + ONE;
        else       nv = (u == '0) ? t10 + ((room > NINE) ? NINE : room) : value_q - ONE;
      end else begin
        if (inc_e) nv = (t10 + TEN <= MAXV) ? value_q + TEN : u;
        else       nv = (t10 != '0) ? value_q - TEN : MAXT10 + u;
      end
      value_d = (nv > MAXV) ? MAXV : nv;
    end else if (!editMode && tick) begin
      if (value_q == MAXV) begin
        value_d = '0;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + ONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge KEY0) begin
    if (!KEY0) begin
      presc_q <= '0;
      fast_q  <= 1'b0;
      em_q    <= 1'b0;
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      fast_q  <= fast;
      em_q    <= editMode;
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value  = value_q;
  assign carry  = carry_q;
  assign at_max = value_q == MAXV;

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench: free-running prescaled counter, chained wrap, and a table of digit edits on a modulo-24 stage.
module tb_time_unit_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic KEY0;
  logic fast0, em0;
  logic cin1, em1, inc1_n, dec1_n;
  logic [2:0] cur1;
  logic [1:0] dm1;
  logic cin2;
  logic [6:0] v0, v1, v2;
  logic c0, c1, c2, m0, m1, m2;

  time_unit_counter #(.MODULO(60), .WIDTH(7), .CHAINED(0), .TICK_DIV(4), .FAST_DIV(2)) dut0 (
    .Clk(Clk), .KEY0(KEY0), .cin(1'b0), .fast(fast0), .editMode(em0), .editCur(3'd0),
    .disMode(2'd0), .inc_n(1'b1), .dec_n(1'b1), .value(v0), .carry(c0), .at_max(m0));

  time_unit_counter #(.MODULO(24), .WIDTH(7), .CHAINED(1), .TICK_DIV(4), .FAST_DIV(2)) dut1 (
    .Clk(Clk), .KEY0(KEY0), .cin(cin1), .fast(1'b0), .editMode(em1), .editCur(cur1),
    .disMode(dm1), .inc_n(inc1_n), .dec_n(dec1_n), .value(v1), .carry(c1), .at_max(m1));

  time_unit_counter #(.MODULO(60), .WIDTH(7), .CHAINED(1), .TICK_DIV(4), .FAST_DIV(2)) dut2 (
    .Clk(Clk), .KEY0(KEY0), .cin(cin2), .fast(1'b0), .editMode(1'b0), .editCur(3'd0),
    .disMode(2'd0), .inc_n(1'b1), .dec_n(1'b1), .value(v2), .carry(c2), .at_max(m2));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cur;
    logic [1:0] dm;
    logic       inc;
    logic       dec;
    logic [6:0] exp;
  } vec_t;

  vec_t tv [18];

  initial begin
    tv[0]  = '{3'd5, 2'd0, 1'b1, 1'b0, 7'd20};
    tv[1]  = '{3'd5, 2'd0, 1'b0, 1'b1, 7'd23};
    tv[2]  = '{3'd4, 2'd0, 1'b1, 1'b0, 7'd3};
    tv[3]  = '{3'd4, 2'd0, 1'b0, 1'b1, 7'd23};
    tv[4]  = '{3'd5, 2'd1, 1'b1, 1'b0, 7'd23};
    tv[5]  = '{3'd0, 2'd0, 1'b1, 1'b0, 7'd23};
    tv[6]  = '{3'd5, 2'd0, 1'b1, 1'b1, 7'd23};
    tv[7]  = '{3'd5, 2'd0, 1'b0, 1'b1, 7'd22};
    tv[8]  = '{3'd4, 2'd0, 1'b0, 1'b1, 7'd12};
    tv[9]  = '{3'd4, 2'd0, 1'b0, 1'b1, 7'd2};
    tv[10] = '{3'd4, 2'd0, 1'b0, 1'b1, 7'd22};
    tv[11] = '{3'd4, 2'd0, 1'b1, 1'b0, 7'd2};
    tv[12] = '{3'd5, 2'd0, 1'b0, 1'b1, 7'd1};
    tv[13] = '{3'd5, 2'd0, 1'b0, 1'b1, 7'd0};
    tv[14] = '{3'd5, 2'd0, 1'b0, 1'b1, 7'd9};
    tv[15] = '{3'd5, 2'd0, 1'b1, 1'b0, 7'd0};
    tv[16] = '{3'd4, 2'd0, 1'b0, 1'b1, 7'd20};
    tv[17] = '{3'd5, 2'd0, 1'b1, 1'b0, 7'd21};

    KEY0 = 1'b0; fast0 = 1'b0; em0 = 1'b0;
    cin1 = 1'b0; em1 = 1'b0; inc1_n = 1'b1; dec1_n = 1'b1; cur1 = 3'd5; dm1 = 2'd0;
    cin2 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_v0", v0, 0);
    chk("rst_c0", c0, 0);
    chk("rst_m0", m0, 0);
    chk("rst_v1", v1, 0);
    chk("rst_v2", v2, 0);
    chk("rst_c2", c2, 0);

    // Free-running stage: tick every 4 clocks after reset release.
    KEY0 = 1'b1;
    repeat (3) @(negedge Clk);
    chk("pre_first_tick", v0, 0);
    @(negedge Clk);
    chk("first_tick", v0, 1);
    repeat (232) @(negedge Clk);
    chk("reach_59", v0, 59);
    chk("at_max_59", m0, 1);
    chk("no_carry_59", c0, 0);
    repeat (3) @(negedge Clk);
    chk("hold_59", v0, 59);
    @(negedge Clk);
    chk("wrap_value", v0, 0);
    chk("wrap_carry", c0, 1);
    chk("wrap_at_max", m0, 0);
    @(negedge Clk);
    chk("carry_one_cycle", c0, 0);
    fast0 = 1'b1;
    @(negedge Clk);
    chk("fast_switch_clears", v0, 0);
    @(negedge Clk);
    chk("fast_pre_tick", v0, 0);
    @(negedge Clk);
    chk("fast_tick1", v0, 1);
    repeat (2) @(negedge Clk);
    chk("fast_tick2", v0, 2);
    @(negedge Clk);
    fast0 = 1'b0;
    @(negedge Clk);
    chk("slow_switch_clears", v0, 2);
    repeat (3) @(negedge Clk);
    chk("slow_restart_hold", v0, 2);
    @(negedge Clk);
    chk("slow_restart_tick", v0, 3);
    em0 = 1'b1;
    repeat (10) @(negedge Clk);
    chk("edit_frozen_v0", v0, 3);
    chk("edit_frozen_c0", c0, 0);
    em0 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("leave_edit_hold", v0, 3);
    @(negedge Clk);
    chk("leave_edit_tick", v0, 4);

    // Chained modulo-60 stage.
    cin2 = 1'b1;
    repeat (59) @(negedge Clk);
    cin2 = 1'b0;
    chk("chain_59", v2, 59);
    chk("chain_at_max", m2, 1);
    cin2 = 1'b1;
    @(negedge Clk);
    cin2 = 1'b0;
    chk("chain_wrap_v", v2, 0);
    chk("chain_wrap_c", c2, 1);
    @(negedge Clk);
    chk("chain_carry_drop", c2, 0);

    // Modulo-24 stage: preset to 23, then frozen under edit.
    cin1 = 1'b1;
    repeat (23) @(negedge Clk);
    cin1 = 1'b0;
    chk("m24_preset", v1, 23);
    chk("m24_at_max", m1, 1);
    em1 = 1'b1;
    cin1 = 1'b1;
    repeat (3) @(negedge Clk);
    cin1 = 1'b0;
    chk("m24_frozen_v", v1, 23);
    chk("m24_frozen_c", c1, 0);

    for (int i = 0; i < 18; i++) begin
      cur1 = tv[i].cur;
      dm1  = tv[i].dm;
      @(negedge Clk);
      if (tv[i].inc) inc1_n = 1'b0;
      if (tv[i].dec) dec1_n = 1'b0;
      repeat (4) @(negedge Clk);
      inc1_n = 1'b1;
      dec1_n = 1'b1;
      repeat (4) @(negedge Clk);
      chk($sformatf("edit_vec%0d_value", i), v1, 32'(tv[i].exp));
      chk($sformatf("edit_vec%0d_carry", i), c1, 0);
    end

    // Press-to-update latency, and holding produces a single event.
    cur1 = 3'd5; dm1 = 2'd0;
    inc1_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("latency_before", v1, 21);
    @(negedge Clk);
    chk("latency_after", v1, 22);
    repeat (10) @(negedge Clk);
    chk("hold_single_event", v1, 22);
    inc1_n = 1'b1;
    repeat (4) @(negedge Clk);

    // editMode drops during the press-event cycle: press applies, cin ignored, counting next cycle.
    inc1_n = 1'b0;
    repeat (3) @(negedge Clk);
    em1  = 1'b0;
    cin1 = 1'b1;
    @(negedge Clk);
    chk("em_fall_press_v", v1, 23);
    chk("em_fall_press_c", c1, 0);
    @(negedge Clk);
    cin1 = 1'b0;
    chk("em_fall_resume_v", v1, 0);
    chk("em_fall_resume_c", c1, 1);
    inc1_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Async reset in the middle of a press.
    cin1 = 1'b1;
    repeat (5) @(negedge Clk);
    cin1 = 1'b0;
    em1 = 1'b1;
    inc1_n = 1'b0;
    repeat (2) @(negedge Clk);
    #2 KEY0 = 1'b0;
    #1;
    chk("async_rst_v0", v0, 0);
    chk("async_rst_v1", v1, 0);
    chk("async_rst_v2", v2, 0);
    chk("async_rst_c1", c1, 0);
    @(negedge Clk);
    inc1_n = 1'b1;
    @(negedge Clk);
    KEY0 = 1'b1;
    repeat (6) @(negedge Clk);
    chk("post_rst_no_event", v1, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
